// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle plus the word-wide data memory port of the MEM stage.
// The load/store unit takes the slave view; the core and memory side take the master view.
interface mem_access_unit_if;
    logic        i_req;
    logic        i_wr;
    logic [1:0]  i_size;
    logic        i_sign_ext;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_DMem_we;
    logic [31:0] o_DMem_addr;
    logic [31:0] o_DMem_wData;
    logic [31:0] i_DMem_rData;

    modport slave (
        input  i_req, i_wr, i_size, i_sign_ext, i_addr, i_wdata, i_DMem_rData,
        output o_busy, o_done, o_rdata, o_misaligned, o_DMem_we, o_DMem_addr, o_DMem_wData
    );

    modport master (
        output i_req, i_wr, i_size, i_sign_ext, i_addr, i_wdata, i_DMem_rData,
        input  o_busy, o_done, o_rdata, o_misaligned, o_DMem_we, o_DMem_addr, o_DMem_wData
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: byte/half/word accesses over a word-wide memory,
// read-modify-write for sub-word stores, load extension and misalignment trapping.
module mem_access_unit #(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state_reg, state_next;
    logic        wr_reg;
    logic [1:0]  size_reg;
    logic        sext_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;
    logic        mis_reg;
    logic [31:0] rdata_reg;
    logic [31:0] daddr_reg;
    logic [31:0] dwdata_reg;

    logic        accept;
    logic        mis_in;
    logic        trap_in;
    logic [1:0]  size_in;
    logic [1:0]  off_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    assign accept = (state_reg == IDLE) && bus.i_req;

    // Reserved size is treated as a word access when trapping is disabled; the lane
    // offset is truncated to the access size so untrapped misaligned accesses align down.
    always_comb begin
        mis_in  = 1'b0;
        size_in = bus.i_size;
        off_in  = 2'b00;
        case (bus.i_size)
            2'b00: off_in = bus.i_addr[1:0];
            2'b01: begin
                mis_in = bus.i_addr[0];
                off_in = {bus.i_addr[1], 1'b0};
            end
            2'b10: mis_in = |bus.i_addr[1:0];
            default: begin
                mis_in  = 1'b1;
                size_in = 2'b10;
            end
        endcase
    end

    assign trap_in = MISALIGN_TRAP && mis_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (trap_in)                             state_next = DONE;
                    else if (bus.i_wr && size_in == 2'b10)   state_next = WR;
                    else                                     state_next = RD;
                end
            end
            RD:      state_next = wr_reg ? WR : DONE;
            WR:      state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign ld_byte = bus.i_DMem_rData[{off_reg, 3'b000} +: 8];
    assign ld_half = off_reg[1] ? bus.i_DMem_rData[31:16] : bus.i_DMem_rData[15:0];

    always_comb begin
        case (size_reg)
            2'b00:   ld_ext = {{24{sext_reg & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{sext_reg & ld_half[15]}}, ld_half};
            default: ld_ext = bus.i_DMem_rData;
        endcase
    end

    // Per-lane merge of store data into the word read back during RD.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign merged[8*gi +: 8] =
            (size_reg == 2'b00 && off_reg == LANE)       ? wdata_reg[7:0] :
            (size_reg == 2'b01 && off_reg[1] == LANE[1]) ? wdata_reg[8*(gi%2) +: 8] :
                                                           bus.i_DMem_rData[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_reg     <= 1'b0;
            size_reg   <= 2'b00;
            sext_reg   <= 1'b0;
            off_reg    <= 2'b00;
            wdata_reg  <= 16'h0;
            mis_reg    <= 1'b0;
            rdata_reg  <= 32'h0;
            daddr_reg  <= 32'h0;
            dwdata_reg <= 32'h0;
        end else begin
            if (accept) begin
                wr_reg    <= bus.i_wr;
                size_reg  <= size_in;
                sext_reg  <= bus.i_sign_ext;
                off_reg   <= off_in;
                wdata_reg <= bus.i_wdata[15:0];
                mis_reg   <= trap_in;
                // A trapped access leaves the memory port untouched.
                if (!trap_in) begin
                    daddr_reg <= {bus.i_addr[31:2], 2'b00};
                    if (bus.i_wr && size_in == 2'b10)
                        dwdata_reg <= bus.i_wdata;
                end
            end
            if (state_reg == RD) begin
                if (wr_reg) dwdata_reg <= merged;
                else        rdata_reg  <= ld_ext;
            end
        end
    end

    assign bus.o_busy       = (state_reg != IDLE);
    assign bus.o_done       = (state_reg == DONE);
    assign bus.o_DMem_we    = (state_reg == WR);
    assign bus.o_rdata      = rdata_reg;
    assign bus.o_misaligned = mis_reg;
    assign bus.o_DMem_addr  = daddr_reg;
    assign bus.o_DMem_wData = dwdata_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected completions and memory
// writes into queues; independent monitors pop and compare on o_done and o_DMem_we.
module tb_mem_access_unit;
    logic clk;
    logic rstn;
    logic preload;
    logic [31:0] mem [0:63];

    mem_access_unit_if dif ();

    mem_access_unit #(.MISALIGN_TRAP(1'b1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dif.i_DMem_rData = mem[dif.o_DMem_addr[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h8899AABB;   // 0x10
            mem[9] <= 32'h11223344;   // 0x24
        end else if (dif.o_DMem_we) begin
            mem[dif.o_DMem_addr[7:2]] <= dif.o_DMem_wData;
        end
    end

    typedef struct {
        string       nm;
        logic [31:0] rdata;
        logic        mis;
    } done_exp_t;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int exp_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        if (rstn && dif.o_done) begin
            done_exp_t e;
            done_cnt++;
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got o_done=1 expected no completion");
            end else begin
                e = done_q.pop_front();
                $display("txn %s rdata=%08h mis=%0b", e.nm, dif.o_rdata, dif.o_misaligned);
                check({e.nm, "_rdata"}, dif.o_rdata, e.rdata);
                check({e.nm, "_mis"}, {31'h0, dif.o_misaligned}, {31'h0, e.mis});
            end
        end
    end

    // Memory write monitor
    always @(negedge clk) begin
        if (dif.o_DMem_we) begin
            wr_exp_t w;
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got we=1 addr=%08h data=%08h expected no write",
                         dif.o_DMem_addr, dif.o_DMem_wData);
            end else begin
                w = wr_q.pop_front();
                $display("wr %s addr=%08h data=%08h", w.nm, dif.o_DMem_addr, dif.o_DMem_wData);
                check({w.nm, "_waddr"}, dif.o_DMem_addr, w.addr);
                check({w.nm, "_wdata"}, dif.o_DMem_wData, w.data);
            end
        end
    end

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        dif.i_wr       = wr;
        dif.i_size     = sz;
        dif.i_sign_ext = sx;
        dif.i_addr     = a;
        dif.i_wdata    = wd;
    endtask

    // Waits (sampling 1 time unit after each rising edge) until o_done, bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dif.o_done && n < 12);
    endtask

    task automatic do_acc(input string nm, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic [31:0] er, input logic em,
                          input logic ew, input logic [31:0] ewd);
        int n;
        done_q.push_back('{nm, er, em});
        exp_done++;
        if (ew) wr_q.push_back('{nm, {a[31:2], 2'b00}, ewd});
        @(negedge clk);
        drive(wr, sz, sx, a, wd);
        dif.i_req = 1'b1;
        @(posedge clk);
        #1;
        dif.i_req = 1'b0;
        n = 1;
        while (!dif.o_done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_latency"}, n, lat);
        @(posedge clk);
    endtask

    initial begin
        int n;
        rstn    = 1'b0;
        preload = 1'b1;
        dif.i_req = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        preload = 1'b0;
        check("rst_busy",  {31'h0, dif.o_busy}, 32'h0);
        check("rst_done",  {31'h0, dif.o_done}, 32'h0);
        check("rst_we",    {31'h0, dif.o_DMem_we}, 32'h0);
        check("rst_mis",   {31'h0, dif.o_misaligned}, 32'h0);
        check("rst_rdata", dif.o_rdata, 32'h0);
        check("rst_daddr", dif.o_DMem_addr, 32'h0);
        check("rst_dwdata", dif.o_DMem_wData, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);

        //     name       wr    size   sx    addr        wdata        lat  rdata         mis   wr?   wdata
        do_acc("lb_s",    1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        2, 32'hFFFFFF99, 1'b0, 1'b0, 32'h0);
        do_acc("lb_z",    1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        2, 32'h00000099, 1'b0, 1'b0, 32'h0);
        do_acc("sb",      1'b1, 2'b00, 1'b0, 32'h11, 32'h5A,       3, 32'h00000099, 1'b0, 1'b1, 32'h88995ABB);
        do_acc("lw",      1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'h88995ABB, 1'b0, 1'b0, 32'h0);
        do_acc("sw",      1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 2, 32'h88995ABB, 1'b0, 1'b1, 32'hDEADBEEF);
        do_acc("lh_s",    1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        2, 32'hFFFFDEAD, 1'b0, 1'b0, 32'h0);
        do_acc("lw_mis",  1'b0, 2'b10, 1'b0, 32'h21, 32'h0,        1, 32'hFFFFDEAD, 1'b1, 1'b0, 32'h0);
        do_acc("sh_mis",  1'b1, 2'b01, 1'b0, 32'h23, 32'h1234,     1, 32'hFFFFDEAD, 1'b1, 1'b0, 32'h0);
        do_acc("lw_chk",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        do_acc("sh_hi",   1'b1, 2'b01, 1'b0, 32'h12, 32'h5566,     3, 32'hDEADBEEF, 1'b0, 1'b1, 32'h55665ABB);
        do_acc("lb_lane0",1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        2, 32'hFFFFFFBB, 1'b0, 1'b0, 32'h0);
        do_acc("lh_z",    1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        2, 32'h00005ABB, 1'b0, 1'b0, 32'h0);
        do_acc("rsv_mis", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1, 32'h00005ABB, 1'b1, 1'b0, 32'h0);

        // i_req held high; fields and i_req toggled while busy must have no effect
        done_q.push_back('{"b2b_a", 32'h000000EF, 1'b0});
        done_q.push_back('{"b2b_b", 32'hFFFFBEEF, 1'b0});
        exp_done += 2;
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        dif.i_req = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 2'b10, 1'b0, 32'h30, 32'hBAD0BAD0);
        dif.i_req = 1'b0;
        @(negedge clk);
        dif.i_req = 1'b1;
        wait_done(n);
        check("b2b_a_latency", n, 1);
        drive(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        wait_done(n);
        check("b2b_b_period", n, 3);
        dif.i_req = 1'b0;
        @(posedge clk);

        // Reset during the RD state of a sub-word store
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h24, 32'h77);
        dif.i_req = 1'b1;
        @(posedge clk);
        #1;
        dif.i_req = 1'b0;
        check("rd_busy", {31'h0, dif.o_busy}, 32'h1);
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_we",    {31'h0, dif.o_DMem_we}, 32'h0);
        check("mid_rst_busy",  {31'h0, dif.o_busy}, 32'h0);
        check("mid_rst_rdata", dif.o_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_busy", {31'h0, dif.o_busy}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        do_acc("lw_post", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0,        2, 32'h11223344, 1'b0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("done_q_empty", done_q.size(), 0);
        check("wr_q_empty",   wr_q.size(), 0);
        check("done_count",   done_cnt, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller for the multi-cycle CPU's MEM stage.
- Drives the word-wide data memory port: write enable, address, write data, and combinational read data.
- Accepts byte, halfword and word requests from the core.
- Performs read-modify-write for sub-word stores, and sign/zero extension and misalignment detection for loads.

Parameters:
- MISALIGN_TRAP, 1: 1 = misaligned or reserved-size requests complete with o_misaligned and no memory write; 0 = address low bits are truncated to the access size and the access proceeds.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- i_req  in  1  request strobe; sampled only in IDLE
- i_wr  in  1  1 = store, 0 = load
- i_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- i_sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-aligned
- o_busy  out  1  high in every non-IDLE state
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  32  extended load result; held until the next accepted request
- o_misaligned  out  1  valid with o_done; held with o_rdata
- o_DMem_we  out  1  memory write enable
- o_DMem_addr  out  32  word-aligned address {addr[31:2], 2'b00}
- o_DMem_wData  out  32  memory write word
- i_DMem_rData  in  32  memory read word, combinational from o_DMem_addr

Behaviour:
- Reset (async): state = IDLE; o_busy, o_done, o_DMem_we, o_misaligned = 0; o_rdata = 0; o_DMem_addr = 0; o_DMem_wData = 0.
- A request is accepted when i_req = 1 in IDLE. On that edge, addr, wr, size, sign_ext and wdata are latched.
- i_req is ignored while o_busy = 1. Inputs may change freely after acceptance.
- Memory byte order is little-endian: byte lane k = word bits [8k+7:8k], lane = addr[1:0].
- Misaligned condition: half with addr[0] = 1; word with addr[1:0] != 0; size 11 with any address.
- FSM states: IDLE, RD, WR, DONE.
- IDLE -> DONE when the request is misaligned and MISALIGN_TRAP = 1. No memory access occurs; o_misaligned = 1.
- IDLE -> WR for a word store.
- IDLE -> RD for a load or a sub-word store.
- RD: o_DMem_addr is driven and i_DMem_rData is captured into a word register at the end of the cycle. Next state is DONE for a load, WR for a sub-word store.
- WR: o_DMem_we = 1 for exactly this one cycle.
  - Word store: o_DMem_wData = latched wdata.
  - Sub-word store: o_DMem_wData = captured word with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
- DONE: o_done = 1 for one cycle; next state is IDLE.
- Load result is registered on entry to DONE:
  - byte = lane byte extended to 32 bits;
  - half = lanes {addr[1]*2+1, addr[1]*2} extended;
  - word = captured word.
- Latency in cycles from the accept edge to o_done high:
  - load = 2;
  - word store = 2;
  - sub-word store = 3;
  - trapped misaligned access = 1.
- A new i_req may be accepted in the cycle after DONE (IDLE); back-to-back throughput is one access per latency + 1 cycles.
- o_DMem_we is decoded from the registered state only. It is never high outside WR and never high for a trapped access.
- o_DMem_addr and o_DMem_wData hold their last value in IDLE.
- Reset asserted mid-operation: o_DMem_we drops immediately and the FSM returns to IDLE. A WR cycle cut by reset leaves memory contents undefined for that word only. No o_done is produced.
- Address wrap is the memory's responsibility: the full 32-bit word-aligned address is always passed through.
- Simultaneous i_req with DONE: ignored, because the state is not IDLE.

Test Plan:
- Memory word 0x10 = 0x8899AABB. Load byte at addr 0x12 with sign_ext = 1 -> o_rdata = 0xFFFFFF99, o_done 2 cycles after accept, o_DMem_we never high. Same access with sign_ext = 0 -> 0x00000099.
- Store byte 0x5A at addr 0x11 over 0x8899AABB -> one WR cycle with o_DMem_wData = 0x88995ABB at o_DMem_addr = 0x10; o_done at cycle 3. A subsequent word load returns 0x88995ABB.
- Store word 0xDEADBEEF at 0x20 -> WR in the first cycle after accept, o_done at cycle 2. Halfword load at 0x22 with sign_ext = 1 -> 0xFFFFDEAD.
- Word load at 0x21 with MISALIGN_TRAP = 1 -> o_done and o_misaligned 1 cycle after accept, no RD or WR, o_rdata unchanged. Halfword store at 0x23 -> memory untouched.
- i_req held high continuously with alternating requests -> each accepted only in IDLE, o_done pulses exactly once per access, and toggling i_req while busy has no effect.
- Assert rstn low during the RD state of a sub-word store -> o_DMem_we stays 0, state IDLE, no o_done. After release, a fresh load completes normally.
